servo_pwm_decoder: RTL and testbench

- Measures the high time of a hobby-servo PWM pulse train and recovers the 8-bit position code that produced it. It is the inverse of the servo_pwm encoder.
- Used for closed-loop self-test: each servoN output is looped back into the FPGA, so the commanded ang_servo_N can be compared with the position actually emitted.
- Also usable on external servo-signal inputs.
- Sits beside controlador_etapa; results feed LEDs, SevenSeg or the serial link.

---
 rtl/servo_pkg.sv | 18 +
 rtl/sync_edge.sv | 20 ++
 rtl/servo_pwm_decoder.sv | 134 +++++++++++++
 tb/tb_servo_pwm_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo timing defaults and decoder state encoding.
package servo_pkg;

  localparam int unsigned DEF_MIN_PULSE_CYC = 50000;
  localparam int unsigned DEF_STEP_CYC      = 196;
  localparam int unsigned DEF_PERIOD_CYC    = 1000000;
  localparam int unsigned DEF_TIMEOUT_CYC   = 2000000;
  localparam int unsigned DEF_CNT_W         = 21;

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    WAIT_LOW,
    DIVIDE,
    DONE
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus edge register; strobes are valid 3 cycles after the input edge.
module sync_edge (
  input  logic clk,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] sh;

  // Synchronizer chain is deliberately left out of reset so a level already
  // present when reset releases never produces a spurious edge strobe.
  always_ff @(posedge clk) begin
    sh <= {sh[1:0], din};
  end

  assign rise_c = sh[1] & ~sh[2];
  assign fall_c = ~sh[1] & sh[2];

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures pulse high time and recovers the 8-bit position code.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
  parameter int unsigned STEP_CYC      = DEF_STEP_CYC,
  parameter int unsigned PERIOD_CYC    = DEF_PERIOD_CYC,
  parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] pos,
  output logic       pos_valid,
  output logic       err_short,
  output logic       err_long,
  output logic       timeout
);

  state_t           state;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] tcnt;
  logic [8:0]       q;
  logic             div_init;
  logic             rise_c;
  logic             fall_c;

  sync_edge u_sync (
    .clk    (clk),
    .din    (pwm_in),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Free-running no-edge counter; cleared by every rise, saturates at the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (rise_c) begin
      tcnt <= '0;
    end else if (tcnt != CNT_W'(TIMEOUT_CYC)) begin
      tcnt <= tcnt + CNT_W'(1);
    end
  end

  // Pulse measurement and serial divide FSM with registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      width     <= '0;
      rem       <= '0;
      q         <= '0;
      div_init  <= 1'b0;
      pos       <= '0;
      pos_valid <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      if (tcnt == CNT_W'(TIMEOUT_CYC)) timeout <= 1'b1;

      case (state)
        IDLE: begin
          if (rise_c) begin
            width <= CNT_W'(1);
            state <= HIGH;
          end
        end

        HIGH: begin
          if (fall_c) begin
            div_init <= 1'b1;
            state    <= DIVIDE;
          end else if (width == CNT_W'(PERIOD_CYC)) begin
            err_long  <= 1'b1;
            err_short <= 1'b0;
            state     <= WAIT_LOW;
          end else begin
            width <= width + CNT_W'(1);
          end
        end

        WAIT_LOW: begin
          if (fall_c) state <= IDLE;
        end

        DIVIDE: begin
          if (div_init) begin
            div_init <= 1'b0;
            if (width < CNT_W'(MIN_PULSE_CYC)) begin
              pos       <= '0;
              err_short <= 1'b1;
              err_long  <= 1'b0;
              pos_valid <= 1'b1;
              timeout   <= 1'b0;
              state     <= DONE;
            end else begin
              // Half-step bias turns the floor division into round-to-nearest.
              rem <= width - CNT_W'(MIN_PULSE_CYC) + CNT_W'(STEP_CYC / 2);
              q   <= '0;
            end
          end else if (q[8] || (rem < CNT_W'(STEP_CYC))) begin
            if (q[8]) begin
              pos      <= 8'hFF;
              err_long <= 1'b1;
            end else begin
              pos      <= q[7:0];
              err_long <= 1'b0;
            end
            err_short <= 1'b0;
            pos_valid <= 1'b1;
            timeout   <= 1'b0;
            state     <= DONE;
          end else begin
            rem <= rem - CNT_W'(STEP_CYC);
            q   <= q + 9'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder using scaled-down timing parameters.
module tb_servo_pwm_decoder;

  localparam int unsigned MIN_P  = 100;
  localparam int unsigned STEP   = 4;
  localparam int unsigned PERIOD = 2000;
  localparam int unsigned TMO    = 4000;
  localparam int unsigned W      = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] pos;
  logic       pos_valid;
  logic       err_short;
  logic       err_long;
  logic       timeout;

  int total   = 0;
  int bad     = 0;
  int nstrobe = 0;

  servo_pwm_decoder #(
    .MIN_PULSE_CYC (MIN_P),
    .STEP_CYC      (STEP),
    .PERIOD_CYC    (PERIOD),
    .TIMEOUT_CYC   (TMO),
    .CNT_W         (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .pos       (pos),
    .pos_valid (pos_valid),
    .err_short (err_short),
    .err_long  (err_long),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && pos_valid) nstrobe++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // High for exactly n sampled cycles.
  task automatic pulse(input int n);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 pwm_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (pos_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic decode(input string tag, input int n, input int exp_pos,
                        input int exp_s, input int exp_l, input int exp_lat);
    int lat;
    pulse(n);
    wait_valid(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_pos"}, 32'(pos), 32'(exp_pos));
    chk({tag, "_short"}, 32'(err_short), 32'(exp_s));
    chk({tag, "_long"}, 32'(err_long), 32'(exp_l));
    chk({tag, "_tmo"}, 32'(timeout), 32'd0);
    @(posedge clk);
    #1 chk({tag, "_onecyc"}, 32'(pos_valid), 32'd0);
    repeat (400) @(posedge clk);
  endtask

  initial begin
    int s;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_valid", 32'(pos_valid), 32'd0);
    chk("rst_short", 32'(err_short), 32'd0);
    chk("rst_long", 32'(err_long), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    repeat (20) @(posedge clk);

    // tag, high cycles, pos, err_short, err_long, latency from fall
    decode("min",      100,  0,   0, 0, 5);
    decode("mid",      612,  128, 0, 0, 133);
    decode("rnd_down", 613,  128, 0, 0, 133);
    decode("rnd_up",   614,  129, 0, 0, 134);
    decode("short",    80,   0,   1, 0, 4);
    decode("max",      1120, 255, 0, 0, 260);
    decode("over",     1300, 255, 0, 1, 261);
    decode("clr_long", 612,  128, 0, 0, 133);
    decode("over2",    1300, 255, 0, 1, 261);

    // Held high past the frame length: flagged, no decode.
    s = nstrobe;
    pulse(2400);
    #1;
    chk("hold_long", 32'(err_long), 32'd1);
    chk("hold_short", 32'(err_short), 32'd0);
    chk("hold_pos", 32'(pos), 32'd255);
    repeat (400) @(posedge clk);
    #1;
    chk("hold_nostrobe", 32'(nstrobe), 32'(s));
    chk("hold_long_after", 32'(err_long), 32'd1);

    // Timeout after reset with input idle.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3900) @(posedge clk);
    #1 chk("tmo_early", 32'(timeout), 32'd0);
    repeat (200) @(posedge clk);
    #1 chk("tmo_set", 32'(timeout), 32'd1);
    decode("tmo_clr", 304, 51, 0, 0, 56);

    // Reset in the middle of a pulse: that pulse is dropped.
    decode("pre_rst", 80, 0, 1, 0, 4);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_pos", 32'(pos), 32'd0);
    chk("mrst_short", 32'(err_short), 32'd0);
    chk("mrst_valid", 32'(pos_valid), 32'd0);
    s = nstrobe;
    repeat (312) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (400) @(posedge clk);
    #1 chk("mrst_nostrobe", 32'(nstrobe), 32'(s));
    decode("post_rst", 612, 128, 0, 0, 133);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
